// File: rtl/ysyx_22041207_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding and default widths.
// Pure package, no logic.
// Not applicable.
package ysyx_22041207_pipe_ctrl_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

endpackage

// File: rtl/ysyx_22041207_pipe_ctrl_if.sv
// Pipeline status/control bundle between the stage registers and the sequencer.
// Wires only, no latency.
// Not applicable.
interface ysyx_22041207_pipe_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs1_ren;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs2_ren;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              ex_redirect;
    logic              mem_req;
    logic              mem_ready;
    logic              if_ready;

    logic              pc_hold;
    logic              ifid_bubble;
    logic              ifid_flush;
    logic              idex_flush;
    logic              ex_hold;
    logic              mem_hold;

    modport master (
        output id_valid, id_rs1, id_rs1_ren, id_rs2, id_rs2_ren,
               ex_valid, ex_rd, ex_is_load, ex_redirect,
               mem_req, mem_ready, if_ready,
        input  pc_hold, ifid_bubble, ifid_flush, idex_flush, ex_hold, mem_hold
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_ren, id_rs2, id_rs2_ren,
               ex_valid, ex_rd, ex_is_load, ex_redirect,
               mem_req, mem_ready, if_ready,
        output pc_hold, ifid_bubble, ifid_flush, idex_flush, ex_hold, mem_hold
    );
endinterface

// File: rtl/ysyx_22041207_pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
// Latency: combinational.
// Backpressure: none; result feeds the sequencer's stall decision.
module ysyx_22041207_pipe_ctrl_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_ren,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_ren,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    output logic              hazard
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_ren && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_ren && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never produces a hazard
    assign hazard = id_valid && ex_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/ysyx_22041207_pipe_ctrl.sv
// Pipeline sequencer: prioritises LSU wait > redirect > load-use > IF wait into hold/flush.
// Latency: outputs combinational from state and inputs; state and perf counters update on posedge.
// Backpressure: pc_hold/ifid_bubble/ex_hold/mem_hold freeze stages; flushes insert NOPs.
module ysyx_22041207_pipe_ctrl
    import ysyx_22041207_pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ysyx_22041207_pipe_ctrl_if.slave       pif,
    output logic [1:0]                     state_o,
    output logic [CNT_W-1:0]               cnt_stall,
    output logic [CNT_W-1:0]               cnt_flush
);
    state_e state_q;
    state_e state_d;
    logic   hazard;
    logic   redir_acc;
    logic   pc_hold, ifid_bubble, ifid_flush, idex_flush, ex_hold, mem_hold;
    logic   mem_wait;

    ysyx_22041207_pipe_ctrl_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .id_valid   (pif.id_valid),
        .id_rs1     (pif.id_rs1),
        .id_rs1_ren (pif.id_rs1_ren),
        .id_rs2     (pif.id_rs2),
        .id_rs2_ren (pif.id_rs2_ren),
        .ex_valid   (pif.ex_valid),
        .ex_rd      (pif.ex_rd),
        .ex_is_load (pif.ex_is_load),
        .hazard     (hazard)
    );

    assign mem_wait = pif.mem_req && !pif.mem_ready;

    always_comb begin
        state_d     = ST_RUN;
        redir_acc   = 1'b0;
        pc_hold     = 1'b0;
        ifid_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        ex_hold     = 1'b0;
        mem_hold    = 1'b0;
        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        {pc_hold, ifid_bubble, ex_hold, mem_hold} = 4'b1111;
                        state_d = ST_MEM_WAIT;
                    end else if (pif.ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        redir_acc  = 1'b1;
                        state_d    = pif.if_ready ? ST_RUN : ST_DRAIN;
                    end else if (hazard) begin
                        pc_hold     = 1'b1;
                        ifid_bubble = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (!pif.if_ready) begin
                        pc_hold    = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                // EX is frozen, so a pending redirect or hazard re-presents once back in RUN
                ST_MEM_WAIT: begin
                    if (!pif.mem_ready) begin
                        {pc_hold, ifid_bubble, ex_hold, mem_hold} = 4'b1111;
                        state_d = ST_MEM_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (mem_wait) begin
                        {pc_hold, ifid_bubble, ex_hold, mem_hold} = 4'b1111;
                        state_d = ST_MEM_WAIT;
                    end else if (pif.ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        redir_acc  = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        ifid_flush = 1'b1;
                        state_d    = pif.if_ready ? ST_RUN : ST_DRAIN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_stall <= '0;
            cnt_flush <= '0;
        end else begin
            state_q <= state_d;
            if (pc_hold && (cnt_stall != {CNT_W{1'b1}}))
                cnt_stall <= cnt_stall + CNT_W'(1);
            if (redir_acc && (cnt_flush != {CNT_W{1'b1}}))
                cnt_flush <= cnt_flush + CNT_W'(1);
        end
    end

    assign state_o         = state_q;
    assign pif.pc_hold     = pc_hold;
    assign pif.ifid_bubble = ifid_bubble;
    assign pif.ifid_flush  = ifid_flush;
    assign pif.idex_flush  = idex_flush;
    assign pif.ex_hold     = ex_hold;
    assign pif.mem_hold    = mem_hold;
endmodule

// File: tb/tb_ysyx_22041207_pipe_ctrl.sv
// Directed bench for the pipeline sequencer.
// Output vector order: {pc_hold, ifid_bubble, ifid_flush, idex_flush, ex_hold, mem_hold}.
module tb_ysyx_22041207_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]  state_o;
    logic [31:0] cnt_stall;
    logic [31:0] cnt_flush;
    int total = 0;
    int bad   = 0;

    ysyx_22041207_pipe_ctrl_if #(.REG_AW(5)) pif ();

    ysyx_22041207_pipe_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pif       (pif.slave),
        .state_o   (state_o),
        .cnt_stall (cnt_stall),
        .cnt_flush (cnt_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {pif.pc_hold, pif.ifid_bubble, pif.ifid_flush,
                pif.idex_flush, pif.ex_hold, pif.mem_hold};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pif.id_valid    = 1'b0;
        pif.id_rs1      = 5'd0;
        pif.id_rs1_ren  = 1'b0;
        pif.id_rs2      = 5'd0;
        pif.id_rs2_ren  = 1'b0;
        pif.ex_valid    = 1'b0;
        pif.ex_rd       = 5'd0;
        pif.ex_is_load  = 1'b0;
        pif.ex_redirect = 1'b0;
        pif.mem_req     = 1'b0;
        pif.mem_ready   = 1'b0;
        pif.if_ready    = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_outs", outs(), 6'b001100);
        chk("rst_state", state_o, 2'd0);
        chk("rst_cnt_stall", cnt_stall, 0);
        chk("rst_cnt_flush", cnt_flush, 0);
        #10 rst_n = 1'b1;
        next_cycle();
        chk("idle_outs", outs(), 6'b000000);

        // load-use on rs1
        pif.ex_valid = 1'b1; pif.ex_is_load = 1'b1; pif.ex_rd = 5'd5;
        pif.id_valid = 1'b1; pif.id_rs1 = 5'd5; pif.id_rs1_ren = 1'b1;
        #1 chk("lu_stall_outs", outs(), 6'b110100);
        next_cycle();
        pif.ex_valid = 1'b0; pif.ex_is_load = 1'b0;
        #1 chk("lu_after_outs", outs(), 6'b000000);
        chk("lu_cnt_stall", cnt_stall, 1);
        chk("lu_state", state_o, 2'd0);

        // load to x0
        pif.ex_valid = 1'b1; pif.ex_is_load = 1'b1; pif.ex_rd = 5'd0;
        pif.id_rs1 = 5'd0;
        #1 chk("x0_outs", outs(), 6'b000000);
        next_cycle();
        chk("x0_cnt_stall", cnt_stall, 1);

        // load-use via rs2, then same regs with rs2 not read
        pif.ex_rd = 5'd7; pif.id_rs1 = 5'd3; pif.id_rs2 = 5'd7; pif.id_rs2_ren = 1'b1;
        #1 chk("rs2_stall_outs", outs(), 6'b110100);
        pif.id_rs2_ren = 1'b0;
        #1 chk("rs2_noren_outs", outs(), 6'b000000);
        pif.id_rs2_ren = 1'b1;
        next_cycle();
        chk("rs2_cnt_stall", cnt_stall, 2);

        // redirect beats hazard
        pif.ex_rd = 5'd5; pif.id_rs1 = 5'd5; pif.ex_redirect = 1'b1;
        #1 chk("redir_lu_outs", outs(), 6'b001100);
        next_cycle();
        idle();
        #1 chk("redir_cnt_flush", cnt_flush, 1);
        chk("redir_cnt_stall", cnt_stall, 2);
        chk("redir_state", state_o, 2'd0);

        // IF wait
        pif.if_ready = 1'b0;
        #1 chk("ifwait_outs", outs(), 6'b101000);
        next_cycle();
        pif.if_ready = 1'b1;
        chk("ifwait_cnt_stall", cnt_stall, 3);

        // LSU wait: three frozen cycles then release
        pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
        #1 chk("mw1_outs", outs(), 6'b110011);
        next_cycle();
        chk("mw2_state", state_o, 2'd1);
        pif.ex_redirect = 1'b1;
        #1 chk("mw2_outs_redir_ignored", outs(), 6'b110011);
        next_cycle();
        pif.ex_redirect = 1'b0;
        #1 chk("mw3_outs", outs(), 6'b110011);
        chk("mw3_cnt_flush", cnt_flush, 1);
        next_cycle();
        pif.mem_ready = 1'b1;
        #1 chk("mw4_release_outs", outs(), 6'b000000);
        chk("mw4_state", state_o, 2'd1);
        next_cycle();
        idle();
        #1 chk("mw_done_state", state_o, 2'd0);
        chk("mw_cnt_stall", cnt_stall, 6);

        // redirect with a fetch still in flight for two cycles
        pif.ex_redirect = 1'b1; pif.if_ready = 1'b0;
        #1 chk("dr1_outs", outs(), 6'b001100);
        next_cycle();
        pif.ex_redirect = 1'b0;
        #1 chk("dr2_state", state_o, 2'd2);
        chk("dr2_outs", outs(), 6'b001000);
        chk("dr2_cnt_flush", cnt_flush, 2);
        next_cycle();
        pif.if_ready = 1'b1;
        #1 chk("dr3_state", state_o, 2'd2);
        chk("dr3_outs", outs(), 6'b001000);
        next_cycle();
        chk("dr_done_state", state_o, 2'd0);
        chk("dr_done_outs", outs(), 6'b000000);
        chk("dr_cnt_flush", cnt_flush, 2);
        chk("dr_cnt_stall", cnt_stall, 6);

        // async reset while in MEM_WAIT
        pif.mem_req = 1'b1; pif.mem_ready = 1'b0;
        next_cycle();
        chk("rst2_pre_state", state_o, 2'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst2_state", state_o, 2'd0);
        chk("rst2_cnt_stall", cnt_stall, 0);
        chk("rst2_cnt_flush", cnt_flush, 0);
        chk("rst2_outs", outs(), 6'b001100);
        next_cycle();
        chk("rst2_hold_state", state_o, 2'd0);
        chk("rst2_hold_outs", outs(), 6'b001100);
        idle();
        rst_n = 1'b1;
        next_cycle();
        chk("rst2_release_state", state_o, 2'd0);
        chk("rst2_release_outs", outs(), 6'b000000);
        chk("rst2_release_cnt", cnt_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
